// File: rtl/app_ui_pkg.sv
// Shared types and helpers for the push-button/switch UI block.
package app_ui_pkg;

    typedef struct packed {
        logic held;
        logic press;
        logic released;
    } key_evt_t;

    localparam int SYNC_STAGES = 2;

    function automatic int debounce_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/app_ui_debounce.sv
// One key: pin synchroniser, counter debounce, registered held/press/release events.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from pin edge to held/pulse; no backpressure.
// Auto-repeat press pulses only when APP_UI_AUTOREPEAT_EN is defined.
module app_ui_debounce
    import app_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     key_n,
    output key_evt_t evt
);

    localparam int            CW       = debounce_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   stable;
    logic [CW-1:0]          cnt;
    logic                   raw;

    assign raw = sync[SYNC_STAGES-1];

`ifdef APP_UI_AUTOREPEAT_EN
    localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = debounce_width(RMAX);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt;
    logic          rphase;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '1;
            stable <= 1'b1;
            cnt    <= '0;
            evt    <= '0;
`ifdef APP_UI_AUTOREPEAT_EN
            rcnt   <= '0;
            rphase <= 1'b0;
`endif
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], key_n};
            evt.press    <= 1'b0;
            evt.released <= 1'b0;

            if (raw == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable       <= raw;
                cnt          <= '0;
                evt.held     <= ~raw;
                evt.press    <= ~raw;
                evt.released <= raw;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

`ifdef APP_UI_AUTOREPEAT_EN
            // An accepted transition restarts the schedule and wins over a coincident repeat.
            if (raw != stable && cnt == CNT_LAST) begin
                rcnt   <= '0;
                rphase <= 1'b0;
            end else if (!stable) begin
                if (rcnt == (rphase ? RP_LAST : RD_LAST)) begin
                    rcnt      <= '0;
                    rphase    <= 1'b1;
                    evt.press <= 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/app_ui_keypad.sv
// N-key debounced keypad with switch capture per press and per-key toggle flags.
// Latency: 2 (reset release) / 2 + DEBOUNCE_CYCLES from pin edge to pulse; no backpressure.
// Build option APP_UI_AUTOREPEAT_EN adds held-key auto-repeat press pulses.
module app_ui_keypad
    import app_ui_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int SW_W            = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RESET_VALUE     = 11,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_KEYS-1:0]      key_n,
    input  logic [SW_W-1:0]        sw,
    output logic [N_KEYS-1:0]      key_held,
    output logic [N_KEYS-1:0]      key_press,
    output logic [N_KEYS-1:0]      key_release,
    output logic [N_KEYS-1:0]      key_toggle,
    output logic [N_KEYS*SW_W-1:0] key_value
);

    localparam logic [SW_W-1:0] RST_SLOT = SW_W'(RESET_VALUE);

    logic [1:0]                       rst_pipe;
    logic                             rst_n_int;
    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync;
    key_evt_t                         evt [N_KEYS];

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n_int = rst_pipe[1];

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        app_ui_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_deb (
            .clock   (clock),
            .reset_n (rst_n_int),
            .key_n   (key_n[k]),
            .evt     (evt[k])
        );
        assign key_held[k]    = evt[k].held;
        assign key_press[k]   = evt[k].press;
        assign key_release[k] = evt[k].released;
    end

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            sw_sync    <= '0;
            key_toggle <= '0;
            for (int k = 0; k < N_KEYS; k++) key_value[k*SW_W +: SW_W] <= RST_SLOT;
        end else begin
            sw_sync <= {sw_sync[SYNC_STAGES-2:0], sw};
            for (int k = 0; k < N_KEYS; k++) begin
                if (key_press[k]) begin
                    key_value[k*SW_W +: SW_W] <= sw_sync[SYNC_STAGES-1];
                    key_toggle[k]             <= ~key_toggle[k];
                end
            end
        end
    end

endmodule
